intc_vec: RTL and testbench
===========================

Name: intc_vec

Overview:
Parametrised vectored interrupt controller for the next-generation single-cycle CPU. It replaces the single intr/inta pair with NSRC prioritised sources and per-source masking. Each source is configured as edge- or level-triggered, and nesting is tracked by an in-service register. The controller presents the CPU with a held interrupt request, the source id and a handler vector address, and retires nesting levels on end-of-interrupt (EOI).

Parameters:
NSRC, 8, number of interrupt sources (2..32); index 0 has the highest priority.
IDW, $clog2(NSRC), width of the source id.
EDGE, {NSRC{1'b1}}, per-source mode bitmask: 1 = rising-edge triggered, 0 = level triggered.
BASE, 32'h00000008, vector base address.
STRIDE, 32'h00000010, vector spacing in bytes.

Ports:
clk  in  1  clock; all state updates on the rising edge
clrn  in  1  asynchronous active-low reset
irq  in  NSRC  raw interrupt sources, synchronous to clk
ien  in  1  global interrupt enable (CPU status IE bit)
mask_we  in  1  write enable for the mask register
mask_wd  in  NSRC  mask write data; 1 = source enabled
eoi  in  1  end-of-interrupt pulse
eoi_id  in  IDW  source retired by eoi
inta  in  1  CPU acknowledge, one-cycle pulse
intr  out  1  interrupt request to the CPU
id  out  IDW  id of the requested source
vec  out  32  handler entry address: BASE + id*STRIDE (32-bit, wraps)
mask  out  NSRC  current mask register
pend  out  NSRC  current pending register
isr  out  NSRC  current in-service register

Behaviour:
- Reset (asynchronous, clrn=0) clears: mask, pend, isr, irq_d (registered irq), id, intr; state = IDLE; vec = BASE. Takes effect mid-operation, including while in REQ.
- Pending update, every edge:
  - edge source i: pend[i] sets on irq[i] & ~irq_d[i]; it clears only when inta acknowledges id=i.
  - level source i: pend[i] <= irq[i].
- Eligibility: elig = pend & mask & above(isr), where above(isr) keeps only indices strictly lower than the lowest set bit of isr (all ones if isr==0).
  - Consequence: a source never re-interrupts itself or an equal or lower priority while in service.
- Arbitration: a fixed-priority encoder picks the lowest set index of elig.
- FSM states: IDLE, REQ.
  - IDLE -> REQ when ien & |elig. On that edge, id <= winner and vec <= BASE + winner*STRIDE; intr <= 1.
  - REQ: intr, id and vec are held stable regardless of irq, mask, ien or newly arriving higher-priority sources. There is no re-arbitration and no withdrawal.
  - REQ -> IDLE on inta: isr[id] <= 1; pend[id] <= 0 if EDGE[id]; intr <= 0. A new arbitration can start on the following edge (back-to-back nesting is allowed).
  - inta in IDLE is ignored (no state change).
- Latency: a source edge sampled at edge k sets pend after k; intr rises after edge k+1. The same two-edge latency applies to level sources.
- EOI: eoi clears isr[eoi_id]. If eoi_id >= NSRC or isr[eoi_id]==0, there is no effect.
- Simultaneous events:
  - inta and eoi on the same id in one cycle: the set wins (isr bit ends at 1).
  - Different ids: both apply.
  - Edge rising on the same cycle inta clears that pend bit: pend ends at 1, so the new edge is not lost.
  - mask_we: the new mask affects eligibility from the next edge; it does not cancel REQ.
- mask, pend and isr outputs are the registered values.

Decomposition:
- Package intc_pkg holds:
  - state enum {IDLE, REQ}
  - function above_mask(isr) returning the strictly-higher-priority mask
  - function vec_addr(id) = BASE + id*STRIDE
- One sub-module, intc_prio_enc: NSRC-bit request in, IDW-bit index plus valid out. Purely combinational, lowest index wins.

Test Plan:
- Reset then idle: clrn=0 mid-REQ -> intr=0, id=0, vec=32'h08, mask=pend=isr=0 immediately.
- Single edge source: mask=8'h08, ien=1, pulse irq[3] at edge k -> intr=1 after edge k+1, id=3, vec=32'h38. inta -> isr=8'h08, pend=0, intr=0.
- Priority and hold: irq[5] then irq[1] arrives while in REQ for id 5 -> id stays 5 until inta. Next cycle REQ for id 1 (nesting), vec=32'h18; isr=8'h22 after both inta.
- Nesting block: isr=8'h04, pend[6] set -> no intr. eoi with eoi_id=2 -> intr after next edge, id=6.
- Level source: EDGE=8'hFE, irq[0] held high, mask=1 -> request, inta, isr[0]=1, no re-request. eoi with irq[0] still high -> re-request id 0. Drop irq[0] -> pend[0]=0 next edge.
- Gating and collisions: ien=0 with pend=8'hFF, mask=8'hFF -> intr stays 0. inta+eoi same id -> isr bit stays 1. New edge coincident with inta -> pend bit stays 1.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
// Helpers work on 32-bit vectors; callers truncate to their source count.
package intc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // Bits strictly below the lowest set bit of isr_v; all ones when isr_v is zero.
    function automatic logic [31:0] above_mask(input logic [31:0] isr_v);
        logic [31:0] low_v;
        low_v = isr_v & (~isr_v + 32'd1);
        return low_v - 32'd1;
    endfunction

    function automatic logic [31:0] vec_addr(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] idx
    );
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module intc_prio_enc #(
    parameter int NSRC = 8,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  idx,
    output logic            valid
);

    // Scan from the lowest priority upward so the lowest index overwrites last.
    always_comb begin
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            idx = req[i] ? IDW'(i) : idx;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/intc_vec.sv
// Vectored interrupt controller: prioritised, maskable sources with nesting
// tracked by an in-service register and a held request towards the CPU.
module intc_vec
    import intc_pkg::*;
#(
    parameter int              NSRC   = 8,
    parameter int              IDW    = $clog2(NSRC),
    parameter logic [NSRC-1:0] EDGE   = {NSRC{1'b1}},
    parameter logic [31:0]     BASE   = 32'h0000_0008,
    parameter logic [31:0]     STRIDE = 32'h0000_0010
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [NSRC-1:0] irq,
    input  logic            ien,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wd,
    input  logic            eoi,
    input  logic [IDW-1:0]  eoi_id,
    input  logic            inta,
    output logic            intr,
    output logic [IDW-1:0]  id,
    output logic [31:0]     vec,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] pend,
    output logic [NSRC-1:0] isr
);

    state_e          state_r, state_nx_s;
    logic [NSRC-1:0] mask_r, pend_r, isr_r, irq_d_r;
    logic [NSRC-1:0] pend_nx_s, isr_nx_s, above_s, elig_s, ack_oh_s, eoi_oh_s;
    logic [IDW-1:0]  id_r, win_id_s;
    logic            win_vld_s, intr_r, ack_s, start_s;
    logic [31:0]     vec_r;

    assign above_s  = NSRC'(above_mask(32'(isr_r)));
    assign elig_s   = pend_r & mask_r & above_s;
    // Out-of-range eoi_id shifts past the source bits and is dropped by the cast.
    assign eoi_oh_s = eoi   ? NSRC'(32'd1 << eoi_id) : {NSRC{1'b0}};
    assign ack_oh_s = ack_s ? NSRC'(32'd1 << id_r)   : {NSRC{1'b0}};

    intc_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio_enc (
        .req   (elig_s),
        .idx   (win_id_s),
        .valid (win_vld_s)
    );

    // Next-state logic: request is held in REQ until the CPU acknowledges.
    always_comb begin
        state_nx_s = state_r;
        ack_s      = 1'b0;
        start_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (ien && win_vld_s) begin
                    state_nx_s = REQ;
                    start_s    = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (inta) begin
                    state_nx_s = IDLE;
                    ack_s      = 1'b1;
                end else begin
                    state_nx_s = REQ;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Pending/in-service update; a new edge beats the ack clear, the ack set beats eoi.
    always_comb begin
        pend_nx_s = pend_r;
        for (int i = 0; i < NSRC; i++) begin
            if (EDGE[i]) begin
                pend_nx_s[i] = (pend_r[i] & ~ack_oh_s[i]) | (irq[i] & ~irq_d_r[i]);
            end else begin
                pend_nx_s[i] = irq[i];
            end
        end
        isr_nx_s = (isr_r & ~eoi_oh_s) | ack_oh_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath registers; id and vec are captured only when a request starts.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mask_r  <= '0;
            pend_r  <= '0;
            isr_r   <= '0;
            irq_d_r <= '0;
            id_r    <= '0;
            vec_r   <= BASE;
            intr_r  <= 1'b0;
        end else begin
            mask_r  <= mask_we ? mask_wd : mask_r;
            pend_r  <= pend_nx_s;
            isr_r   <= isr_nx_s;
            irq_d_r <= irq;
            intr_r  <= (state_nx_s == REQ);
            if (start_s) begin
                id_r  <= win_id_s;
                vec_r <= vec_addr(BASE, STRIDE, 32'(win_id_s));
            end
        end
    end

    assign intr = intr_r;
    assign id   = id_r;
    assign vec  = vec_r;
    assign mask = mask_r;
    assign pend = pend_r;
    assign isr  = isr_r;

endmodule

// File: tb/tb_intc_vec.sv
// Self-checking bench for intc_vec: expected request ids are queued as
// stimulus is driven and compared when the controller raises intr.
module tb_intc_vec;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

    logic            clk = 1'b0;
    logic            clrn;
    logic [NSRC-1:0] irq;
    logic            ien, mask_we, eoi, inta;
    logic [NSRC-1:0] mask_wd;
    logic [IDW-1:0]  eoi_id;
    logic            intr;
    logic [IDW-1:0]  id;
    logic [31:0]     vec;
    logic [NSRC-1:0] mask, pend, isr;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    intc_vec #(
        .NSRC   (NSRC),
        .EDGE   (8'hFE),
        .BASE   (32'h0000_0008),
        .STRIDE (32'h0000_0010)
    ) u_dut (
        .clk     (clk),
        .clrn    (clrn),
        .irq     (irq),
        .ien     (ien),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .eoi     (eoi),
        .eoi_id  (eoi_id),
        .inta    (inta),
        .intr    (intr),
        .id      (id),
        .vec     (vec),
        .mask    (mask),
        .pend    (pend),
        .isr     (isr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [NSRC-1:0] m);
        mask_we = 1'b1;
        mask_wd = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_irq(input int src);
        irq[src] = 1'b1;
        tick();
        irq[src] = 1'b0;
    endtask

    // Wait (bounded) for intr, then pop the expected id and compare id/vec.
    task automatic wait_req(input string tag);
        int exp_id;
        for (int n = 0; n < 20 && intr !== 1'b1; n++) tick();
        if (intr !== 1'b1) begin
            check({tag, "_timeout"}, 32'(intr), 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(id), 32'hFFFF_FFFF);
        end else begin
            exp_id = exp_q.pop_front();
            check({tag, "_id"}, 32'(id), 32'(exp_id));
            check({tag, "_vec"}, vec, 32'h08 + 32'(exp_id) * 32'h10);
        end
    endtask

    task automatic do_ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        check("ack_intr_drop", 32'(intr), 32'd0);
    endtask

    task automatic do_eoi(input int src);
        eoi    = 1'b1;
        eoi_id = IDW'(src);
        tick();
        eoi    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clrn = 1'b0; irq = '0; ien = 1'b0; mask_we = 1'b0; mask_wd = '0;
        eoi = 1'b0; eoi_id = '0; inta = 1'b0;
        tick(); tick();
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_vec", vec, 32'h08);
        check("rst_regs", {8'h00, mask, pend, isr}, 32'h0);
        clrn = 1'b1;
        tick();

        // Single edge source with two-edge latency
        ien = 1'b1;
        write_mask(8'h08);
        irq[3] = 1'b1;
        exp_q.push_back(3);
        tick();
        check("lat_pend", 32'(pend), 32'h08);
        check("lat_intr_low", 32'(intr), 32'd0);
        irq[3] = 1'b0;
        tick();
        check("lat_intr_high", 32'(intr), 32'd1);
        wait_req("single");
        do_ack();
        check("single_isr", 32'(isr), 32'h08);
        check("single_pend", 32'(pend), 32'h00);
        do_eoi(3);
        check("single_eoi", 32'(isr), 32'h00);

        // Priority hold and back-to-back nesting
        write_mask(8'hFE);
        exp_q.push_back(5);
        pulse_irq(5);
        tick();
        pulse_irq(1);
        tick();
        check("hold_intr", 32'(intr), 32'd1);
        check("hold_id", 32'(id), 32'd5);
        check("hold_pend", 32'(pend), 32'h22);
        wait_req("hold");
        exp_q.push_back(1);
        do_ack();
        check("nest_isr1", 32'(isr), 32'h20);
        wait_req("nest");
        do_ack();
        check("nest_isr2", 32'(isr), 32'h22);
        do_eoi(1);
        do_eoi(5);
        check("nest_eoi", 32'(isr), 32'h00);

        // Lower priority blocked while a higher one is in service
        exp_q.push_back(2);
        pulse_irq(2);
        wait_req("blk_src2");
        do_ack();
        check("blk_isr", 32'(isr), 32'h04);
        pulse_irq(6);
        tick(); tick();
        check("blk_pend", 32'(pend), 32'h40);
        check("blk_no_intr", 32'(intr), 32'd0);
        exp_q.push_back(6);
        do_eoi(2);
        wait_req("blk_after_eoi");
        do_ack();
        do_eoi(6);

        // Level-triggered source 0
        write_mask(8'h01);
        irq[0] = 1'b1;
        exp_q.push_back(0);
        wait_req("lvl_first");
        do_ack();
        check("lvl_isr", 32'(isr), 32'h01);
        tick(); tick();
        check("lvl_no_rereq", 32'(intr), 32'd0);
        check("lvl_pend_held", 32'(pend), 32'h01);
        exp_q.push_back(0);
        do_eoi(0);
        wait_req("lvl_rereq");
        do_ack();
        irq[0] = 1'b0;
        tick();
        check("lvl_drop", 32'(pend), 32'h00);
        do_eoi(0);

        // Global gating and collisions
        ien = 1'b0;
        write_mask(8'hFF);
        irq = 8'hFF;
        tick();
        irq = 8'h01;
        tick();
        check("gate_pend", 32'(pend), 32'hFF);
        tick();
        check("gate_no_intr", 32'(intr), 32'd0);
        ien = 1'b1;
        exp_q.push_back(0);
        wait_req("gate_open");
        do_ack();
        irq = 8'h00;
        exp_q.push_back(1);
        do_eoi(0);
        wait_req("coll_src1");
        inta = 1'b1; eoi = 1'b1; eoi_id = 3'd1; irq[1] = 1'b1;
        tick();
        inta = 1'b0; eoi = 1'b0; irq[1] = 1'b0;
        check("coll_isr", 32'(isr), 32'h02);
        check("coll_pend", 32'(pend), 32'hFE);
        tick();
        check("coll_no_intr", 32'(intr), 32'd0);
        exp_q.push_back(1);
        do_eoi(1);
        wait_req("pre_reset");

        // Asynchronous reset while a request is held
        #3;
        clrn = 1'b0;
        #1;
        check("arst_intr", 32'(intr), 32'd0);
        check("arst_id", 32'(id), 32'd0);
        check("arst_vec", vec, 32'h08);
        check("arst_regs", {8'h00, mask, pend, isr}, 32'h0);
        tick();
        clrn = 1'b1;
        tick();
        check("post_rst_intr", 32'(intr), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
